// File: rtl/approx_mac_accum.sv
// approx_mac_accum: sums a frame of LEN unsigned 8-bit products into an
// ACC_W-bit accumulator and presents the frame sum on a valid/ready output.
// Optional build macro APPROX_MAC_SATURATE_EN: clamp the running sum to all
// ones instead of wrapping modulo 2^ACC_W. The overflow flag is identical in
// both builds.
module approx_mac_accum #(
    parameter int ACC_W = 12,
    parameter int LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic {
        ST_ACCUM,
        ST_OUT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_ovf_q, out_ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] step_val;
    logic             accept;
    logic             last;

    // Accumulate step: zero-extended add, carry out of the MSB, wrap or clamp.
    always_comb begin
        sum    = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, in_prod};
        carry  = sum[ACC_W];
`ifdef APPROX_MAC_SATURATE_EN
        // An all-ones sum plus any nonzero product carries again, so the
        // clamp holds for the rest of the frame without a separate flag.
        step_val = carry ? '1 : sum[ACC_W-1:0];
`else
        step_val = sum[ACC_W-1:0];
`endif
        accept = in_valid && in_ready_q;
        last   = (cnt_q == CNT_LAST);
    end

    // Next-state logic: clr overrides any handshake in the same cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_acc_d = out_acc_q;
        out_ovf_d = out_ovf_q;
        if (clr) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        if (last) begin
                            out_acc_d = step_val;
                            out_ovf_d = ovf_q | carry;
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = ST_OUT;
                        end else begin
                            acc_d = step_val;
                            cnt_d = cnt_q + 8'd1;
                            ovf_d = ovf_q | carry;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (cnt_d != 8'd0) || (state_d == ST_OUT);
    end

    // State and registered outputs with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Bench for approx_mac_accum: three instances (default, ACC_W=10/LEN=8,
// LEN=1) checked against a bench-side frame model through result queues.
// Honors APPROX_MAC_SATURATE_EN for the expected clamped sums.
module tb_approx_mac_accum;

`ifdef APPROX_MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
    localparam int W10_EXP = 1023;
`else
    localparam bit SAT = 1'b0;
    localparam int W10_EXP = 776;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2:0]      clr_v  = '0;
    logic [2:0]      iv     = '0;
    logic [2:0]      ordy   = '0;
    logic [2:0][7:0] ip     = '0;
    logic [2:0]      ir, ov, ovf_v, busy_v;
    logic [11:0]     acc_a, acc_l;
    logic [9:0]      acc_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] qa[$];
    logic [32:0] qw[$];
    logic [32:0] ql[$];

    longint m_acc[3];
    int     m_cnt[3];
    bit     m_ovf[3];
    int     p_w[3] = '{12, 10, 12};
    int     p_l[3] = '{4, 8, 1};

    always #5 clk = ~clk;

    approx_mac_accum #(.ACC_W(12), .LEN(4)) u_a (
        .clk(clk), .rst(rst), .clr(clr_v[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_prod(ip[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_acc(acc_a),
        .out_ovf(ovf_v[0]), .busy(busy_v[0])
    );

    approx_mac_accum #(.ACC_W(10), .LEN(8)) u_w (
        .clk(clk), .rst(rst), .clr(clr_v[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_prod(ip[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_acc(acc_w),
        .out_ovf(ovf_v[1]), .busy(busy_v[1])
    );

    approx_mac_accum #(.ACC_W(12), .LEN(1)) u_l (
        .clk(clk), .rst(rst), .clr(clr_v[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_prod(ip[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_acc(acc_l),
        .out_ovf(ovf_v[2]), .busy(busy_v[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return qa.size();
            1:       return qw.size();
            default: return ql.size();
        endcase
    endfunction

    function automatic void push_exp(input int d, input logic [32:0] v);
        case (d)
            0:       qa.push_back(v);
            1:       qw.push_back(v);
            default: ql.push_back(v);
        endcase
    endfunction

    function automatic void model_clr(input int d);
        m_acc[d] = 0;
        m_cnt[d] = 0;
        m_ovf[d] = 1'b0;
    endfunction

    // Reference frame arithmetic: exact sum, clamp or wrap at 2^W-1.
    function automatic void model_add(input int d, input int prod);
        longint mask;
        longint s;
        mask = (longint'(1) << p_w[d]) - 1;
        s = m_acc[d] + longint'(prod);
        if (s > mask) begin
            m_ovf[d] = 1'b1;
            s = SAT ? mask : (s & mask);
        end
        m_acc[d] = s;
        m_cnt[d]++;
        if (m_cnt[d] == p_l[d]) begin
            push_exp(d, {m_ovf[d], 32'(m_acc[d])});
            model_clr(d);
        end
    endfunction

    // Present one product and hold it until the DUT takes it (bounded).
    task automatic feed(input int d, input int prod);
        bit rdy;
        int n;
        n = 0;
        iv[d] = 1'b1;
        ip[d] = 8'(prod);
        do begin
            rdy = ir[d];
            step();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("feed_timeout", 64'(0), 64'(1));
        else      model_add(d, prod);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain", 64'(qsize(d)), 64'(0));
    endtask

    // Result monitor: every output handshake pops and checks one expected result.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst && ov[0] && ordy[0]) begin
            if (qa.size() == 0) chk("a_unexpected", 64'(0), 64'(1));
            else begin
                e = qa.pop_front();
                chk("a_acc", 64'(acc_a), 64'(e[31:0]));
                chk("a_ovf", 64'(ovf_v[0]), 64'(e[32]));
            end
        end
        if (!rst && ov[1] && ordy[1]) begin
            if (qw.size() == 0) chk("w_unexpected", 64'(0), 64'(1));
            else begin
                e = qw.pop_front();
                chk("w_acc", 64'(acc_w), 64'(e[31:0]));
                chk("w_ovf", 64'(ovf_v[1]), 64'(e[32]));
            end
        end
        if (!rst && ov[2] && ordy[2]) begin
            if (ql.size() == 0) chk("l_unexpected", 64'(0), 64'(1));
            else begin
                e = ql.pop_front();
                chk("l_acc", 64'(acc_l), 64'(e[31:0]));
                chk("l_ovf", 64'(ovf_v[2]), 64'(e[32]));
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) model_clr(d);
        step();
        step();
        chk("rst_in_ready", 64'(ir), 64'(3'b111));
        chk("rst_out_valid", 64'(ov), 64'(0));
        chk("rst_busy", 64'(busy_v), 64'(0));
        chk("rst_acc", 64'(acc_a), 64'(0));
        chk("rst_ovf", 64'(ovf_v), 64'(0));
        rst = 1'b0;
        step();

        // Basic frame, in_valid held, out_ready high.
        ordy[0] = 1'b1;
        feed(0, 225);
        chk("busy_mid", 64'(busy_v[0]), 64'(1));
        feed(0, 200);
        feed(0, 100);
        feed(0, 1);
        iv[0] = 1'b0;
        chk("t1_out_valid", 64'(ov[0]), 64'(1));
        chk("t1_in_ready", 64'(ir[0]), 64'(0));
        chk("t1_acc", 64'(acc_a), 64'(526));
        chk("t1_busy", 64'(busy_v[0]), 64'(1));
        step();
        chk("t1_valid_drop", 64'(ov[0]), 64'(0));
        chk("t1_ready_back", 64'(ir[0]), 64'(1));
        chk("t1_busy_drop", 64'(busy_v[0]), 64'(0));
        drain(0);

        // Back-pressure with a fifth product waiting upstream.
        ordy[0] = 1'b0;
        feed(0, 225);
        feed(0, 200);
        feed(0, 100);
        feed(0, 1);
        ip[0] = 8'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(ov[0]), 64'(1));
            chk("bp_acc", 64'(acc_a), 64'(526));
            chk("bp_in_ready", 64'(ir[0]), 64'(0));
            step();
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_after_hs_ready", 64'(ir[0]), 64'(1));
        chk("bp_not_taken", 64'(busy_v[0]), 64'(0));
        feed(0, 5);
        chk("bp_taken", 64'(busy_v[0]), 64'(1));
        feed(0, 10);
        feed(0, 20);
        feed(0, 30);
        iv[0] = 1'b0;
        drain(0);

        // clr mid-frame, with a product offered in the clr cycle.
        feed(0, 50);
        feed(0, 60);
        feed(0, 70);
        ip[0] = 8'd99;
        clr_v[0] = 1'b1;
        step();
        clr_v[0] = 1'b0;
        iv[0] = 1'b0;
        model_clr(0);
        chk("clr_busy", 64'(busy_v[0]), 64'(0));
        chk("clr_valid", 64'(ov[0]), 64'(0));
        chk("clr_keeps_acc", 64'(acc_a), 64'(65));
        feed(0, 10);
        feed(0, 20);
        feed(0, 30);
        feed(0, 40);
        iv[0] = 1'b0;
        drain(0);

        // Reset while holding a result.
        ordy[0] = 1'b0;
        feed(0, 225);
        feed(0, 200);
        feed(0, 100);
        feed(0, 1);
        iv[0] = 1'b0;
        chk("rst_out_hold", 64'(ov[0]), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        qa.delete();
        model_clr(0);
        chk("rst2_valid", 64'(ov[0]), 64'(0));
        chk("rst2_acc", 64'(acc_a), 64'(0));
        chk("rst2_in_ready", 64'(ir[0]), 64'(1));
        chk("rst2_busy", 64'(busy_v[0]), 64'(0));
        ordy[0] = 1'b1;
        feed(0, 1);
        feed(0, 2);
        feed(0, 3);
        feed(0, 4);
        iv[0] = 1'b0;
        drain(0);

        // ACC_W=10, LEN=8: overflowing frame then a clean one.
        ordy[1] = 1'b0;
        for (int i = 0; i < 8; i++) feed(1, 225);
        iv[1] = 1'b0;
        chk("w10_acc", 64'(acc_w), 64'(W10_EXP));
        chk("w10_ovf", 64'(ovf_v[1]), 64'(1));
        ordy[1] = 1'b1;
        drain(1);
        for (int i = 0; i < 8; i++) feed(1, 100);
        iv[1] = 1'b0;
        chk("w10_clean_acc", 64'(acc_w), 64'(800));
        chk("w10_clean_ovf", 64'(ovf_v[1]), 64'(0));
        drain(1);

        // LEN=1: every product is a frame.
        ordy[2] = 1'b1;
        chk("l1_idle_busy", 64'(busy_v[2]), 64'(0));
        feed(2, 7);
        iv[2] = 1'b0;
        chk("l1_valid_7", 64'(ov[2]), 64'(1));
        chk("l1_acc_7", 64'(acc_l), 64'(7));
        chk("l1_busy_out", 64'(busy_v[2]), 64'(1));
        step();
        chk("l1_valid_drop", 64'(ov[2]), 64'(0));
        chk("l1_busy_drop", 64'(busy_v[2]), 64'(0));
        feed(2, 9);
        iv[2] = 1'b0;
        chk("l1_valid_9", 64'(ov[2]), 64'(1));
        chk("l1_acc_9", 64'(acc_l), 64'(9));
        drain(2);

        step();
        step();
        chk("final_queues", 64'(qa.size() + qw.size() + ql.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
